rr_mux8_arbiter: RTL and testbench
==================================

Name: rr_mux8_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8:1 data mux among 8 requesters.
- Drives the mux select, returns a one-hot grant, and presents the selected channel on a valid/ready output port.
- Bounds each grant to MAX_BEATS transfers so no requester can starve the others.
- Sits between eight producer channels and a single downstream consumer.

Parameters:
- WIDTH, 8, data width per channel
- MAX_BEATS, 4, maximum accepted transfers per grant (>=1)

Ports:
- clk  input  1  rising-edge clock, only clock
- rst  input  1  synchronous active-high reset
- req  input  8  per-channel request, bit i = channel i
- din  input  8*WIDTH  packed channel data, channel i at [i*WIDTH +: WIDTH]
- out_ready  input  1  downstream accepts a beat
- out_valid  output  1  beat presented downstream
- dout  output  WIDTH  selected channel data
- sel  output  3  registered mux select (granted channel index)
- gnt  output  8  registered one-hot grant, all-zero when idle
- ack  output  8  per-channel beat accepted, combinational = gnt & {8{out_valid & out_ready}}

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. Everything is sampled on the rising edge of clk.
- Reset values: state=IDLE, sel=0, gnt=0, beat_cnt=0, last=7 (channel 0 gets highest priority first). Consequently out_valid=0, dout=0, ack=0.
- States:
  - IDLE: gnt=0.
  - GRANT: exactly one gnt bit set, and that bit equals the sel index.
- Arbitration:
  - The winner is the first set bit of req, searching from index last+1 upward and wrapping 7->0.
  - If no bit is set, there is no winner.
- IDLE -> GRANT: taken when |req. sel and gnt load the winner, beat_cnt=0. Latency from req assertion to gnt is 1 cycle.
- GRANT datapath:
  - out_valid = req[sel], combinational.
  - dout = din[sel] while in GRANT, 0 in IDLE.
  - out_valid never depends on out_ready.
- Beat: out_valid & out_ready. On each beat, beat_cnt increments.
- Release: occurs on either condition below.
  - req[sel]=0 in GRANT with no beat.
  - A beat occurs while beat_cnt==MAX_BEATS-1.
- On release:
  - last <= sel.
  - Arbitration runs in the same cycle on the current req, with the pointer already advanced past sel.
  - If there is a winner, the next state is GRANT on that winner (back-to-back, no bubble). Otherwise the next state is IDLE.
  - The released channel can win again only if no other channel is requesting.
- Requester drops req mid-grant: the grant is released the next edge. Beats already taken are final.
- MAX_BEATS=1: pure per-beat round robin.
- Width rules:
  - beat_cnt is $clog2(MAX_BEATS+1) bits and never exceeds MAX_BEATS-1.
  - sel is 3 bits, and wrap arithmetic is modulo 8.
- rst asserted mid-transfer: on the next edge all state returns to reset values. A beat handshaken in the reset cycle is not counted, and the pointer returns to last=7.
- All 8 channels requesting continuously with out_ready=1: the grant order is 0,1,...,7,0, with MAX_BEATS beats each.

Optional Feature:
- Macro: ARB_FIXED_PRI_EN
- Defined: arbitration ignores last and always picks the lowest-index set req bit. The MAX_BEATS limit and release rules are unchanged. last is still updated but unused.
- Undefined: round-robin exactly as specified above.

Test Plan:
- Reset, then req=8'b0000_0001 held, out_ready=1, MAX_BEATS=4 -> gnt=0x01 one cycle after req, then 4 beats, then a new grant to ch0 (sole requester) with no IDLE bubble.
- req=8'hFF held, out_ready=1, din channel i = i*16 -> grants cycle 0..7, each carrying 4 beats of dout = 0x00, 0x10, ..., 0x70 in order, with ack matching gnt.
- Grant on ch2, out_ready=0 for 5 cycles -> out_valid=1, dout held, beat_cnt=0, no release; then out_ready=1 -> 4 beats and release.
- Grant on ch5 after 1 beat, req[5] dropped, req[6]=1 -> out_valid=0 that cycle, gnt=0x40 next cycle, sel=6.
- Mid-grant on ch3 with beat_cnt=2, rst pulsed 1 cycle while req=8'hFF -> gnt=0 after the edge, then the next grant is ch0.
- With ARB_FIXED_PRI_EN defined and req=8'h0A held -> ch1 is granted repeatedly (4 beats per grant) and ch3 is never granted.

Source files
------------

// File: rtl/rr_mux8_arbiter.sv
// rr_mux8_arbiter: round-robin arbiter sharing one 8:1 data mux among eight
// requesters, presenting the granted channel on a valid/ready output port.
// Each grant is limited to MAX_BEATS accepted transfers.
// Optional build macro ARB_FIXED_PRI_EN: lowest-index requester always wins
// (the rotating pointer is still tracked but not consulted).
module rr_mux8_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         req,
    input  logic [8*WIDTH-1:0] din,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   dout,
    output logic [2:0]         sel,
    output logic [7:0]         gnt,
    output logic [7:0]         ack
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_sel, w_sel_nxt;
    logic [2:0]       r_last, w_last_nxt;
    logic [7:0]       r_gnt, w_gnt_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic             w_beat;
    logic             w_release;
    // {found, index} from the arbiter, for the idle start and for release
    logic [3:0]       w_pick_idle;
    logic [3:0]       w_pick_rel;

`ifdef ARB_FIXED_PRI_EN
    // Lowest-index set bit wins; position of the pointer is irrelevant.
    function automatic logic [3:0] f_pick(input logic [7:0] req_v);
        logic [3:0] res;
        res = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            if (req_v[i]) res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

    assign w_pick_idle = f_pick(req);
    assign w_pick_rel  = w_pick_idle;
`else
    // First set bit searching from ptr+1 upward, wrapping 7->0; ptr itself last.
    // Scanning from the far end down lets the nearest candidate overwrite.
    function automatic logic [3:0] f_pick(input logic [7:0] req_v, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int i = 8; i >= 1; i--) begin
            idx = ptr + 3'(i);
            if (req_v[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign w_pick_idle = f_pick(req, r_last);
    assign w_pick_rel  = f_pick(req, r_sel);
`endif

    assign out_valid = (r_state == GRANT) && req[r_sel];
    assign dout      = (r_state == GRANT) ? din[r_sel*WIDTH +: WIDTH] : '0;
    assign w_beat    = out_valid && out_ready;
    assign ack       = r_gnt & {8{w_beat}};
    assign sel       = r_sel;
    assign gnt       = r_gnt;

    // A dropped request frees the grant (no beat is possible then), as does
    // the final allowed beat of the grant.
    assign w_release = (r_state == GRANT) &&
                       (!req[r_sel] || (w_beat && (r_cnt == CNT_LAST)));

    // Next-state: grant start, beat counting, release with same-cycle re-arbitration
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_idle[3]) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_pick_idle[2:0];
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_last_nxt = r_sel;
                    w_cnt_nxt  = '0;
                    if (w_pick_rel[3]) begin
                        w_sel_nxt = w_pick_rel[2:0];
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_beat) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        endcase
        w_gnt_nxt = (w_state_nxt == GRANT) ? (8'b1 << w_sel_nxt) : 8'b0;
    end

    // State, select, grant, beat count and rotating pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= 3'd0;
            r_gnt   <= 8'b0;
            r_cnt   <= '0;
            r_last  <= 3'd7;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Testbench for rr_mux8_arbiter: directed scenarios with a beat scoreboard.
module tb_rr_mux8_arbiter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [7:0]       req;
    logic [8*WIDTH-1:0] din;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] dout;
    logic [2:0]       sel;
    logic [7:0]       gnt;
    logic [7:0]       ack;

    typedef struct packed {
        logic [2:0]       ch;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;

    rr_mux8_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .dout      (dout),
        .sel       (sel),
        .gnt       (gnt),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every accepted beat must match the head of the expected-beat queue.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: got ch=%0d dout=%h, required no beat", sel, dout);
            end else begin
                beat_t e;
                e = sb.pop_front();
                if (sel !== e.ch || dout !== e.data || ack !== (8'b1 << e.ch)) begin
                    bad++;
                    $display("FAIL beat_data: got ch=%0d dout=%h ack=%h, required ch=%0d dout=%h ack=%h",
                             sel, dout, ack, e.ch, e.data, 8'b1 << e.ch);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input int ch, input int n);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.ch   = 3'(ch);
            e.data = WIDTH'(ch * 16);
            sb.push_back(e);
        end
    endtask

    task automatic check_sb_empty(input string name);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL %s_sb_left: got %0d pending beats, required 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        req = 8'h00;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b1;
        req = 8'hFF;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (gnt !== 8'h00) begin bad++; $display("FAIL rst_gnt: got %h, required 00", gnt); end
        total++;
        if (sel !== 3'd0) begin bad++; $display("FAIL rst_sel: got %0d, required 0", sel); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
        total++;
        if (dout !== 8'h00) begin bad++; $display("FAIL rst_dout: got %h, required 00", dout); end
        total++;
        if (ack !== 8'h00) begin bad++; $display("FAIL rst_ack: got %h, required 00", ack); end
        tick();
        rst = 1'b0;
        req = 8'h00;
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h01;
        out_ready = 1'b1;
        push_beats(0, 8);
        @(negedge clk);
        total++;
        if (gnt !== 8'h00 || out_valid !== 1'b0) begin
            bad++; $display("FAIL single_latency: got gnt=%h valid=%b, required gnt=00 valid=0", gnt, out_valid);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (gnt !== 8'h01 || out_valid !== 1'b1) begin
                bad++; $display("FAIL single_gnt[%0d]: got gnt=%h valid=%b, required gnt=01 valid=1", k, gnt, out_valid);
            end
        end
        tick();
        req = 8'h00;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drop_valid: got %b, required 0", out_valid); end
        tick();
        @(negedge clk);
        total++;
        if (gnt !== 8'h00) begin bad++; $display("FAIL single_idle: got gnt=%h, required 00", gnt); end
        check_sb_empty("single");
    endtask

    task automatic test_all_req();
        do_reset();
        req = 8'hFF;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) push_beats(c, 4);
        @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            total++;
            if (gnt !== (8'b1 << (k / 4)) || sel !== 3'(k / 4)) begin
                bad++; $display("FAIL all_order[%0d]: got gnt=%h sel=%0d, required gnt=%h sel=%0d",
                                k, gnt, sel, 8'b1 << (k / 4), k / 4);
            end
        end
        tick();
        req = 8'h00;
        tick();
        @(negedge clk);
        total++;
        if (gnt !== 8'h00) begin bad++; $display("FAIL all_idle: got gnt=%h, required 00", gnt); end
        check_sb_empty("all");
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 8'h14;
        out_ready = 1'b0;
        push_beats(2, 4);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || dout !== 8'h20 || gnt !== 8'h04 || ack !== 8'h00) begin
                bad++; $display("FAIL bp_hold[%0d]: got valid=%b dout=%h gnt=%h ack=%h, required 1 20 04 00",
                                k, out_valid, dout, gnt, ack);
            end
        end
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (gnt !== 8'h04) begin bad++; $display("FAIL bp_beats[%0d]: got gnt=%h, required 04", k, gnt); end
        end
        tick();
        req = 8'h00;
        @(negedge clk);
        total++;
        if (gnt !== 8'h10 || sel !== 3'd4 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release: got gnt=%h sel=%0d valid=%b, required 10 4 0", gnt, sel, out_valid);
        end
        tick();
        @(negedge clk);
        total++;
        if (gnt !== 8'h00) begin bad++; $display("FAIL bp_idle: got gnt=%h, required 00", gnt); end
        check_sb_empty("bp");
    endtask

    task automatic test_drop_req();
        do_reset();
        req = 8'h20;
        out_ready = 1'b1;
        push_beats(5, 1);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (gnt !== 8'h20 || out_valid !== 1'b1) begin
            bad++; $display("FAIL drop_first: got gnt=%h valid=%b, required 20 1", gnt, out_valid);
        end
        tick();
        req = 8'h40;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || gnt !== 8'h20 || ack !== 8'h00) begin
            bad++; $display("FAIL drop_gap: got valid=%b gnt=%h ack=%h, required 0 20 00", out_valid, gnt, ack);
        end
        push_beats(6, 1);
        tick();
        @(negedge clk);
        total++;
        if (gnt !== 8'h40 || sel !== 3'd6 || out_valid !== 1'b1) begin
            bad++; $display("FAIL drop_next: got gnt=%h sel=%0d valid=%b, required 40 6 1", gnt, sel, out_valid);
        end
        tick();
        req = 8'h00;
        tick();
        @(negedge clk);
        total++;
        if (gnt !== 8'h00) begin bad++; $display("FAIL drop_idle: got gnt=%h, required 00", gnt); end
        check_sb_empty("drop");
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h08;
        out_ready = 1'b1;
        push_beats(3, 2);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (gnt !== 8'h08) begin bad++; $display("FAIL midrst_gnt: got gnt=%h, required 08", gnt); end
        @(negedge clk);
        tick();
        rst = 1'b1;
        req = 8'hFF;
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (gnt !== 8'h00 || out_valid !== 1'b0 || ack !== 8'h00) begin
            bad++; $display("FAIL midrst_clear: got gnt=%h valid=%b ack=%h, required 00 0 00", gnt, out_valid, ack);
        end
        push_beats(0, 1);
        tick();
        @(negedge clk);
        total++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            bad++; $display("FAIL midrst_next: got gnt=%h sel=%0d, required 01 0", gnt, sel);
        end
        tick();
        req = 8'h00;
        tick();
        @(negedge clk);
        total++;
        if (gnt !== 8'h00) begin bad++; $display("FAIL midrst_idle: got gnt=%h, required 00", gnt); end
        check_sb_empty("midrst");
    endtask

    task automatic test_priority();
        logic [7:0] exp_gnt;
        do_reset();
        req = 8'h0A;
        out_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
`ifdef ARB_FIXED_PRI_EN
            push_beats(1, 4);
`else
            push_beats((g % 2 == 0) ? 1 : 3, 4);
`endif
        end
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
`ifdef ARB_FIXED_PRI_EN
            exp_gnt = 8'h02;
`else
            exp_gnt = ((k / 4) % 2 == 0) ? 8'h02 : 8'h08;
`endif
            @(negedge clk);
            total++;
            if (gnt !== exp_gnt) begin
                bad++; $display("FAIL prio_gnt[%0d]: got gnt=%h, required %h", k, gnt, exp_gnt);
            end
        end
        tick();
        req = 8'h00;
        tick();
        @(negedge clk);
        total++;
        if (gnt !== 8'h00) begin bad++; $display("FAIL prio_idle: got gnt=%h, required 00", gnt); end
        check_sb_empty("prio");
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) din[i*WIDTH +: WIDTH] = WIDTH'(i * 16);
        test_reset();
        test_single();
        test_all_req();
        test_backpressure();
        test_drop_req();
        test_reset_mid();
        test_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
